// File: rtl/addsub_serial_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
//   state_t    : controller states
//   cnt_width  : width of the digit counter for a given WIDTH/DIGIT pair
package addsub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A single-digit configuration still needs a one-bit counter.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Operation handshake and result bus of addsub_serial.
//   master : issues start/sub/a/b, observes busy/done/out and flags
//   slave  : the adder/subtractor itself
interface addsub_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, out, carry, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, out, carry, overflow, zero
  );
endinterface

// File: rtl/addsub_digit.sv
// DIGIT-bit ripple-carry adder slice.
//   x_i, y_i   : slice operands
//   cin_i      : carry into bit 0
//   s_o        : slice sum
//   cout_o     : carry out of the top bit
//   c_msb_in_o : carry into the top bit (overflow detection)
module addsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x_i,
  input  logic [DIGIT-1:0] y_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] s_o,
  output logic             cout_o,
  output logic             c_msb_in_o
);

  logic c;

  always_comb begin
    s_o        = '0;
    c_msb_in_o = 1'b0;
    c          = cin_i;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in_o = c;
      s_o[i] = x_i[i] ^ y_i[i] ^ c;
      c      = (x_i[i] & y_i[i]) | (x_i[i] & c) | (y_i[i] & c);
    end
    cout_o = c;
  end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : start/sub/a/b in, busy/done/out/carry/overflow/zero out
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | processing digits, busy = 1
// S_DONE | result valid, done = 1 for this cycle; start relaunches
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  addsub_serial_if.slave bus
);

  localparam int             N    = WIDTH / DIGIT;
  localparam int             CW   = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] out_q;
  logic             carry_q, ovf_q, zero_q;

  logic [DIGIT-1:0] s;
  logic             cout, c_msb_in;
  logic [WIDTH-1:0] res_d;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x_i        (a_q[DIGIT-1:0]),
    .y_i        (b_q[DIGIT-1:0]),
    .cin_i      (c_q),
    .s_o        (s),
    .cout_o     (cout),
    .c_msb_in_o (c_msb_in)
  );

  // Sum digits enter at the MSB end; after the last digit res_d holds the
  // whole result, so it is what gets copied to out.
  if (WIDTH > DIGIT) begin : g_acc
    logic [WIDTH-DIGIT-1:0] acc_q;
    assign res_d = {s, acc_q};
    always_ff @(posedge clk) begin
      if (rst)                    acc_q <= '0;
      else if (state_q == S_RUN)  acc_q <= res_d[WIDTH-1:DIGIT];
    end
  end else begin : g_noacc
    assign res_d = s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            c_q     <= bus.sub;  // a + ~b + 1 for subtraction
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          c_q   <= cout;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            out_q   <= res_d;
            carry_q <= cout;
            ovf_q   <= c_msb_in ^ cout;
            zero_q  <= (res_d == '0);
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.out      = out_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised digit-serial adder/subtractor with start/done handshake and status flags. It generalises the team's 4-bit combinational adder/subtractor to any operand width. It processes DIGIT bits per clock, so area trades directly against latency. It sits behind a simple controller or testbench driver that issues one operation at a time and reads the result when `done` pulses.

## Interface
- `WIDTH`, default 8: operand/result width in bits, two's complement; must be ≥ 2.
- `DIGIT`, default 1: bits processed per clock. `WIDTH % DIGIT` must be 0.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only when not busy.
- `sub`  in  1  0 = a + b, 1 = a − b; sampled with `start`.
- `a`  in  WIDTH  first operand; sampled with `start`.
- `b`  in  WIDTH  second operand; sampled with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: result and flags are valid.
- `out`  out  WIDTH  result, a ± b mod 2^WIDTH.
- `carry`  out  1  carry out of the MSB. For subtraction, 1 means no borrow.
- `overflow`  out  1  signed overflow.
- `zero`  out  1  result equals 0.

## Operation
- States:
  - IDLE: `busy` = 0, `done` = 0.
  - RUN: `busy` = 1.
  - DONE: `busy` = 0, `done` = 1.
- Transitions:
  - IDLE → RUN on `start`.
  - RUN → DONE after N = WIDTH/DIGIT digit cycles.
  - DONE → RUN if `start` is high; otherwise DONE → IDLE.
- On an accepted `start`:
  - Latch `a` into a shift register.
  - Latch `b` into a shift register; if `sub` = 1, latch `~b` instead.
  - Set the carry register to `sub`, so subtraction is a + ~b + 1.
  - Clear the digit counter.
- Each RUN cycle:
  - Add the low DIGIT bits of the two shift registers plus the carry register.
  - Shift the DIGIT sum bits into the MSB end of the partial-result register.
  - Shift both operand registers right by DIGIT.
  - Store the carry-out in the carry register.
  - Increment the counter.
- Final digit:
  - `carry` = carry out of bit WIDTH−1.
  - `overflow` = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - The full result is copied into `out`, `carry`, `overflow` and `zero` in the same edge that enters DONE.
- Output holding:
  - `out` and all flags hold their value until the next completion.
  - They never show partial results while RUN is active.
- `start` while in RUN is ignored: no queueing, no effect on the operation in flight.
- Reset:
  - `rst` takes priority over everything.
  - State goes to IDLE; `busy`, `done`, `out`, `carry` and `overflow` go to 0, and `zero` goes to 1.
  - Reset in the middle of RUN aborts the operation; no `done` pulse follows.

## Timing
- Edge E0 samples `start` = 1 in IDLE or DONE.
- `busy` is high in the N cycles after E0. Digits are processed at edges E1..EN.
- At edge EN the outputs update and `done` rises. `done` stays high exactly one cycle.
- Latency from the `start` edge to `done` high: N cycles.
- Back-to-back throughput: one operation every N+1 cycles, because `start` is accepted in the DONE cycle.
- `start` held high continuously re-launches from each DONE cycle, using the operand values present in that cycle.

## Structure
- Package `addsub_pkg` contains:
  - the state enum (`S_IDLE`, `S_RUN`, `S_DONE`);
  - a function returning the counter width, $clog2(WIDTH/DIGIT) with a minimum of 1.
- Sub-module `addsub_digit`:
  - parametrised DIGIT-bit ripple adder slice;
  - ports: x, y, cin → s, cout, and c_msb_in (carry into the slice's top bit, used for overflow).
  - Instantiated once in the top level.
- Top level contains the FSM, counter, shift registers and result/flag registers.

## Test plan
- WIDTH = 4, DIGIT = 1, a = 0111, b = 0100, sub = 0.
  - `done` appears 4 cycles after `start`.
  - `out` = 1011, `carry` = 0, `overflow` = 1, `zero` = 0.
- WIDTH = 4, a = 0010, b = 0111, sub = 1.
  - `out` = 1011 (−5), `carry` = 0, `overflow` = 0.
- WIDTH = 4, a = 1100, b = 0101, sub = 1 (−4 − 5).
  - `out` = 0111, `carry` = 1, `overflow` = 1.
- WIDTH = 4, a = 0011, b = 0011, sub = 1.
  - `out` = 0000, `zero` = 1, `carry` = 1, `overflow` = 0.
- WIDTH = 8, DIGIT = 2, a = 0x7F, b = 0x01, sub = 0.
  - `done` appears 4 cycles after `start`.
  - `out` = 0x80, `overflow` = 1.
  - With `start` held high, the second operation's `done` follows 5 cycles after the first.
- Robustness, WIDTH = 4:
  - Pulse `start` in RUN cycle 2 → no effect on the result; only one `done` pulse.
  - Assert `rst` in RUN cycle 2 → next cycle `busy` = 0, `out` = 0, `zero` = 1, and no `done` pulse.
